// File: rtl/mio_uart_bridge.sv
// Memory-I/O bridge: passes RAM-region accesses to the RAM data port and decodes an
// I/O region holding an 8N1 UART transmitter with a byte FIFO and a status register.
module mio_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] m_a,
  input  logic [31:0] m_d_t,
  input  logic        m_w,
  output logic [31:0] m_d_f,
  output logic [31:0] ram_a,
  output logic [31:0] d_t_ram,
  output logic        wram,
  input  logic [31:0] d_f_ram,
  output logic        txd
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0]   BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0]   BaudOne = BaudW'(1);
  localparam logic [FIFO_AW:0]   CntFull = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   CntOne  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne  = FIFO_AW'(1);
  localparam logic [31:0]        AddrTxData = 32'h8000_0000;
  localparam logic [31:0]        AddrStatus = 32'h8000_0004;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  tx_state_e          r_state;
  logic [BaudW-1:0]   r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_txd;
  logic [7:0]         r_mem [Depth];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;

  logic        w_io;
  logic        w_sel_tx;
  logic        w_sel_st;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic [3:0]  w_cnt_disp;
  logic [31:0] w_status;
  logic [31:0] w_io_rdata;
  logic [2:0]  w_bit_next;

  // Address decode, FIFO flags and status word.
  always_comb begin
    w_io       = m_a[31];
    w_sel_tx   = (m_a == AddrTxData);
    w_sel_st   = (m_a == AddrStatus);
    w_full     = (r_count == CntFull);
    w_empty    = (r_count == '0);
    w_busy     = (r_state != StIdle);
    w_push_req = m_w & w_sel_tx;
    // A push while full is refused even if the transmitter pops this same edge.
    w_push     = w_push_req & ~w_full;
    w_pop      = (r_state == StIdle) & ~w_empty;
    w_cnt_disp = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);
    w_status   = {24'h0, w_cnt_disp, r_ovf, w_busy, w_empty, w_full};
    w_io_rdata = w_sel_st ? w_status : 32'h0;
    w_bit_next = r_bit + 3'd1;
  end

  // RAM pass-through; only RAM-region stores reach the RAM write enable.
  always_comb begin
    ram_a   = m_a;
    d_t_ram = m_d_t;
    wram    = m_w & ~w_io;
    m_d_f   = w_io ? w_io_rdata : d_f_ram;
    txd     = r_txd;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (clrn && w_push) begin
      r_mem[r_wptr] <= m_d_t[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
      if (w_push && !w_pop) begin
        r_count <= r_count + CntOne;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntOne;
      end
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (m_w && w_sel_st) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // 8N1 transmitter with registered serial output.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_txd <= 1'b1;
          if (!w_empty) begin
            r_shift <= r_mem[r_rptr];
            r_baud  <= '0;
            r_bit   <= '0;
            r_txd   <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (r_baud == BaudMax) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
            r_state <= StData;
          end else begin
            r_baud <= r_baud + BaudOne;
          end
        end
        StData: begin
          if (r_baud == BaudMax) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= StStop;
            end else begin
              r_bit <= w_bit_next;
              r_txd <= r_shift[w_bit_next];
            end
          end else begin
            r_baud <= r_baud + BaudOne;
          end
        end
        StStop: begin
          if (r_baud == BaudMax) begin
            r_baud  <= '0;
            r_state <= StIdle;
          end else begin
            r_baud <= r_baud + BaudOne;
          end
        end
        default: begin
          r_state <= StIdle;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_uart_bridge.sv
// Self-checking bench for mio_uart_bridge: frame-level reference model of the FIFO and
// serial line, compared against txd every cycle and against STATUS at chosen points.
module tb_mio_uart_bridge;

  localparam logic [31:0] TxAddr = 32'h8000_0000;
  localparam logic [31:0] StAddr = 32'h8000_0004;
  localparam int          Frame  = 160;

  logic        clk;
  logic        clrn;
  logic [31:0] m_a;
  logic [31:0] m_d_t;
  logic        m_w;
  logic [31:0] m_d_f;
  logic [31:0] ram_a;
  logic [31:0] d_t_ram;
  logic        wram;
  logic [31:0] d_f_ram;
  logic        txd;

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes, sticky overflow, and position within the current frame.
  byte unsigned mq[$];
  bit           m_ovf;
  bit           m_busy;
  int           m_pos;
  logic [7:0]   m_cur;

  logic [31:0] ram [64];

  mio_uart_bridge #(.CLKS_PER_BIT(16), .FIFO_AW(3)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .m_a     (m_a),
    .m_d_t   (m_d_t),
    .m_w     (m_w),
    .m_d_f   (m_d_f),
    .ram_a   (ram_a),
    .d_t_ram (d_t_ram),
    .wram    (wram),
    .d_f_ram (d_f_ram),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple RAM stub behind the data port.
  always @(posedge clk) if (wram) ram[ram_a[7:2]] <= d_t_ram;
  assign d_f_ram = ram[ram_a[7:2]];

  function automatic logic exp_txd();
    if (!m_busy)             return 1'b1;
    if (m_pos < 16)          return 1'b0;
    if (m_pos < 16 + 8 * 16) return m_cur[(m_pos - 16) / 16];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int n = mq.size();
    return {24'h0, 4'(n), m_ovf, m_busy, (n == 0), (n == 8)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT is sampling.
  task automatic model_edge();
    bit pre_full;
    bit pre_empty;
    if (!clrn) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_pos  = 0;
      return;
    end
    pre_full  = (mq.size() == 8);
    pre_empty = (mq.size() == 0);
    if (m_busy) begin
      m_pos++;
      if (m_pos == Frame) m_busy = 1'b0;
    end else if (!pre_empty) begin
      m_cur  = mq.pop_front();
      m_busy = 1'b1;
      m_pos  = 0;
    end
    if (m_w && m_a == TxAddr) begin
      if (pre_full) m_ovf = 1'b1;
      else mq.push_back(m_d_t[7:0]);
    end
    if (m_w && m_a == StAddr) m_ovf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("txd", {31'b0, txd}, {31'b0, exp_txd()});
  endtask

  task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
    m_a   = addr;
    m_d_t = data;
    m_w   = 1'b1;
    tick();
    m_w   = 1'b0;
    m_a   = 32'h0000_0100;
    m_d_t = 32'h0;
  endtask

  task automatic chk_status(input string tag);
    m_a = StAddr;
    m_w = 1'b0;
    #1;
    chk(tag, m_d_f, exp_status());
    m_a = 32'h0000_0100;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i % 53 == 11) chk_status(tag);
    end
  endtask

  initial begin
    int guard;
    logic [7:0] b;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    clrn  = 1'b0;
    m_a   = 32'h0000_0100;
    m_d_t = 32'h0;
    m_w   = 1'b0;
    mq.delete();
    m_ovf  = 1'b0;
    m_busy = 1'b0;
    m_pos  = 0;
    m_cur  = 8'h0;

    // Reset state.
    repeat (3) tick();
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk_status("rst_status");
    clrn = 1'b1;
    tick();

    // RAM pass-through.
    m_a = 32'h0000_00C0; m_d_t = 32'h1234_5678; m_w = 1'b1;
    #1;
    chk("pt_wram", {31'b0, wram}, 32'h1);
    chk("pt_ram_a", ram_a, 32'h0000_00C0);
    chk("pt_d_t_ram", d_t_ram, 32'h1234_5678);
    tick();
    m_w = 1'b0;
    #1;
    chk("pt_load", m_d_f, 32'h1234_5678);
    m_a = StAddr; m_w = 1'b1;
    #1;
    chk("io_wram", {31'b0, wram}, 32'h0);
    m_w = 1'b0;
    m_a = 32'h8000_0010;
    #1;
    chk("io_other_rd", m_d_f, 32'h0);
    io_write(32'h8000_0010, 32'hFF);
    chk_status("pt_status");
    chk("pt_status_const", m_d_f, 32'h0000_0002);

    // Single byte 0x41: txd falls on the edge after the push edge.
    io_write(TxAddr, 32'h41);
    chk("sb_txd_push", {31'b0, txd}, 32'h1);
    tick();
    chk("sb_txd_pop", {31'b0, txd}, 32'h0);
    run(170, "sb_status");
    chk_status("sb_status_end");
    chk("sb_status_const", m_d_f, 32'h0000_0002);

    // Burst of three random bytes on consecutive cycles.
    for (int k = 0; k < 3; k++) io_write(TxAddr, $urandom_range(0, 255));
    chk_status("burst_cnt");
    run(3 * (Frame + 1) + 10, "burst_status");

    // Overflow: ten consecutive pushes with the transmitter starting.
    for (int k = 0; k < 10; k++) io_write(TxAddr, $urandom_range(0, 255));
    chk_status("ovf_status");
    chk("ovf_const", m_d_f, 32'h0000_008D);
    io_write(StAddr, $urandom);
    chk_status("ovf_clear");
    chk("ovf_clear_const", m_d_f, 32'h0000_0085);
    run(9 * (Frame + 1) + 20, "ovf_drain");

    // Wrap: 20 bytes, each pushed on the edge that pops the previous one.
    io_write(TxAddr, $urandom_range(0, 255));
    for (int k = 1; k < 20; k++) begin
      guard = 0;
      while (!(!m_busy && mq.size() == 1) && guard < 400) begin
        tick();
        guard++;
      end
      total++;
      assert (guard < 400) else begin
        bad++;
        $error("FAIL wrap_wait observed=%0d expected<400", guard);
      end
      io_write(TxAddr, $urandom_range(0, 255));
      chk_status("wrap_status");
    end
    run(Frame + 20, "wrap_drain");
    chk_status("wrap_end");

    // Reset in the middle of data bit 3 of 0xC3 with two bytes queued.
    io_write(TxAddr, 32'hC3);
    b = 8'($urandom_range(0, 255));
    io_write(TxAddr, {24'h0, b});
    io_write(TxAddr, $urandom_range(0, 255));
    guard = 0;
    while (!(m_busy && m_cur == 8'hC3 && m_pos == 16 + 3 * 16 + 5) && guard < 400) begin
      tick();
      guard++;
    end
    total++;
    assert (guard < 400) else begin
      bad++;
      $error("FAIL midrst_wait observed=%0d expected<400", guard);
    end
    clrn = 1'b0;
    tick();
    chk("midrst_txd", {31'b0, txd}, 32'h1);
    clrn = 1'b1;
    chk_status("midrst_status");
    chk("midrst_status_const", m_d_f, 32'h0000_0002);
    run(2 * Frame, "midrst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
